// File: rtl/adau_pkg.sv
// Shared constants for the ADAU1761 codec control path: command width,
// arbiter FSM encoding and fixed requester slots.
package adau_pkg;

  localparam int ADAU_CMD_W = 32;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LATCH = 2'd1;
  localparam logic [1:0] ST_ISSUE = 2'd2;

  localparam int REQ_INIT = 0;
  localparam int REQ_VOL  = 1;
  localparam int REQ_CPU  = 2;

endpackage

// File: rtl/adau_rr_picker.sv
// Rotating priority encoder: returns the first set bit of valid_i strictly
// after ptr_i, wrapping around. Purely combinational.
module adau_rr_picker #(
  parameter int N     = 3,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     valid_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [IDX_W-1:0] winner_o,
  output logic             found_o
);

  int idx;

  // NOTE: every output and temporary gets a default at the top of
  // always_comb, so no path through the block can infer a latch.
  always_comb begin
    winner_o = '0;
    found_o  = 1'b0;
    idx      = 0;
    for (int off = 1; off <= N; off++) begin
      idx = (int'(ptr_i) + off) % N;
      if (!found_o && valid_i[idx]) begin
        found_o  = 1'b1;
        winner_o = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/adau_spi_arbiter.sv
// Round-robin arbiter sharing adau_spi_master between command sources, with
// init gating and burst lock. Define ADAU_ARB_WATCHDOG_EN for the ISSUE timeout.
module adau_spi_arbiter
  import adau_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int CMD_W   = ADAU_CMD_W,
  parameter int TIMEOUT = 4096
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     init_done,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ-1:0]       req_lock,
  input  logic [NUM_REQ*CMD_W-1:0] req_cmd,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [CMD_W-1:0]         spi_cmd,
  output logic                     spi_valid,
  input  logic                     spi_ready,
  output logic [NUM_REQ-1:0]       grant,
  output logic                     busy,
  output logic                     timeout_err
);

  localparam int               IDX_W     = $clog2(NUM_REQ);
  localparam logic [IDX_W-1:0] PTR_RESET = IDX_W'(NUM_REQ - 1);

  logic [1:0]         state_q,     state_d;
  logic [IDX_W-1:0]   ptr_q,       ptr_d;
  logic [IDX_W-1:0]   winner_q,    winner_d;
  logic [NUM_REQ-1:0] grant_q,     grant_d;
  logic [CMD_W-1:0]   spi_cmd_q,   spi_cmd_d;
  logic               spi_valid_q, spi_valid_d;

  logic [NUM_REQ-1:0] init_mask;
  logic [NUM_REQ-1:0] elig;
  logic [IDX_W-1:0]   rr_winner;
  logic               rr_found;
  logic               lock_hit;
  logic               wd_fire;

  // Before init completes only the init command list may reach the codec.
  assign init_mask = NUM_REQ'(1) << REQ_INIT;
  assign elig      = init_done ? req_valid : (req_valid & init_mask);

  // The last owner is ptr_q; grant_q is zero only before the first command.
  assign lock_hit = (grant_q != '0) && elig[ptr_q] && req_lock[ptr_q];

  adau_rr_picker #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_picker (
    .valid_i  (elig),
    .ptr_i    (ptr_q),
    .winner_o (rr_winner),
    .found_o  (rr_found)
  );

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    winner_d    = winner_q;
    grant_d     = grant_q;
    spi_cmd_d   = spi_cmd_q;
    spi_valid_d = spi_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (spi_ready && rr_found) begin
          winner_d = lock_hit ? ptr_q : rr_winner;
          state_d  = ST_LATCH;
        end
      end
      ST_LATCH: begin
        spi_cmd_d         = req_cmd[winner_q*CMD_W +: CMD_W];
        grant_d           = '0;
        grant_d[winner_q] = 1'b1;
        ptr_d             = winner_q;
        spi_valid_d       = 1'b1;
        state_d           = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (spi_ready || wd_fire) begin
          spi_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        spi_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  // NOTE: registers use non-blocking assignments so every flop samples the
  // pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      ptr_q       <= PTR_RESET;
      winner_q    <= '0;
      grant_q     <= '0;
      spi_cmd_q   <= '0;
      spi_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      winner_q    <= winner_d;
      grant_q     <= grant_d;
      spi_cmd_q   <= spi_cmd_d;
      spi_valid_q <= spi_valid_d;
    end
  end

  always_comb begin
    req_ready = '0;
    if (state_q == ST_LATCH) begin
      req_ready[winner_q] = 1'b1;
    end
  end

`ifdef ADAU_ARB_WATCHDOG_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] wd_cnt_q, wd_cnt_d;
  logic             wd_err_q, wd_err_d;

  assign wd_fire = (state_q == ST_ISSUE) && !spi_ready &&
                   (wd_cnt_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    wd_cnt_d = wd_cnt_q;
    wd_err_d = wd_err_q | wd_fire;
    if (state_q == ST_LATCH) begin
      wd_cnt_d = '0;
    end else if (state_q == ST_ISSUE && !spi_ready) begin
      wd_cnt_d = wd_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wd_cnt_q <= '0;
      wd_err_q <= 1'b0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
      wd_err_q <= wd_err_d;
    end
  end

  assign timeout_err = wd_err_q;
`else
  assign wd_fire     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  assign spi_cmd   = spi_cmd_q;
  assign spi_valid = spi_valid_q;
  assign grant     = grant_q;
  assign busy      = (state_q != ST_IDLE);

endmodule
